led_shift_driver: RTL and testbench
===================================

Name: led_shift_driver

Overview:
- Downstream stage of the bound flasher.
- Takes the 16-bit thermometer LED vector and serialises it to an external 74HC595-style shift/latch register chain on three pins: sclk, sdo, rclk.
- Re-sends a frame only when the vector changes, so the board LEDs track the flasher with bounded latency.

Parameters:
- WIDTH, 16, number of LED bits per frame.
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 1..255.
- MSB_FIRST, 1, 1 = shift led_in[WIDTH-1] first; 0 = shift led_in[0] first.
- REFRESH_CYCLES, 1000000, idle clk cycles between forced re-sends. Used only when LED_REFRESH_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- led_in  input  WIDTH  LED vector from the flasher; sampled only in IDLE.
- sclk  output  1  serial shift clock to the external register.
- sdo  output  1  serial data; stable for the whole sclk high phase.
- rclk  output  1  storage-latch strobe; high for CLK_DIV cycles at end of frame.
- busy  output  1  high while a frame is in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: sclk=0, sdo=0, rclk=0, busy=0, shadow=0, state=IDLE, init_pending=1.
- All outputs are registered. No combinational path from led_in to any output.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - Start condition: (led_in != shadow) or init_pending.
  - On start, next edge: shift_reg<=led_in, shadow<=led_in, init_pending<=0, busy<=1, bit_cnt<=0, phase_cnt<=0, go SHIFT_LO.
  - On that same edge, sdo is driven with the first bit (MSB_FIRST selects the bit).
- SHIFT_LO:
  - sclk=0 for CLK_DIV cycles, then go SHIFT_HI with sclk<=1.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles, then sclk<=0.
  - If bit_cnt==WIDTH-1: go LATCH, rclk<=1.
  - Otherwise: bit_cnt+1, shift shift_reg, sdo<=next bit, go SHIFT_LO.
- LATCH:
  - rclk=1 for CLK_DIV cycles, then rclk<=0, busy<=0, sdo<=0, go IDLE.
- Frame length: busy is high for exactly 2*CLK_DIV*WIDTH + CLK_DIV cycles; 132 with defaults.
- Minimum IDLE dwell between frames is 1 cycle.
- sdo changes only on the same edge where sclk falls (or at frame start), never while sclk=1.
- led_in changes during a frame are ignored. The IDLE compare after the frame picks up the newest value; intermediate values are dropped by design.
- First frame after reset: sends zeros via init_pending even though led_in==shadow==0. This clears the external chain.
- Reset mid-frame: all outputs drop to reset values immediately (asynchronous). The partial frame is never latched because rclk stays 0. A fresh init frame follows after release.
- CLK_DIV=1: sclk toggles every cycle; same sequence rules apply.
- Counter widths: phase_cnt is 8 bits; bit_cnt is $clog2(WIDTH) bits, with no wrap beyond WIDTH-1.

Optional Feature:
- Macro: LED_REFRESH_EN.
- Defined:
  - A refresh counter runs only while in IDLE; it is cleared on every frame start.
  - When it reaches REFRESH_CYCLES-1, a start condition is forced even if led_in==shadow. This protects against ESD/glitch corruption of the external register.
- Undefined:
  - No counter logic.
  - Frames start only on change or init.

Decomposition:
- Shared package led_drv_pkg:
  - state enum led_drv_state_t {IDLE, SHIFT_LO, SHIFT_HI, LATCH}.
  - LED_WIDTH=16.
  - DEFAULT_CLK_DIV=4.
- One natural sub-module: led_phase_counter.
  - CLK_DIV-cycle counter with clear input and terminal-count pulse.
  - Instantiated once; drives all half-period timing.

Test Plan:
- Reset release, led_in=0 -> one frame of 16 zero bits; rclk pulse 4 cycles wide; busy high 132 cycles; then idle with sclk=0.
- led_in 0x0000->0x001F, MSB_FIRST=1 -> sdo sequence 11 zeros then 5 ones, sampled at sclk rising edges; rclk after bit 16; no further frame while led_in stays stable.
- led_in toggles 0x0003->0x0007->0x000F within one frame -> in-flight frame completes unchanged; exactly one following frame carries 0x000F; 0x0007 is never sent.
- rst_n low at bit 8 of a frame -> sclk/sdo/rclk/busy=0 same cycle; no rclk pulse for the aborted frame; init frame of zeros after release.
- CLK_DIV=1, MSB_FIRST=0, led_in=0x8001 -> sclk period 2 cycles; first and last shifted bits =1; busy 33 cycles.
- LED_REFRESH_EN, REFRESH_CYCLES=50, led_in held at 0x00FF -> identical frame re-sent after every 50 idle cycles.

Source files
------------

// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared types and defaults for the LED shift driver
package led_drv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } led_drv_state_t;

    localparam int LED_WIDTH       = 16;
    localparam int DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/led_shift_driver_if.sv
// rtl/led_shift_driver_if.sv - LED vector input and 74HC595-style serial pins
interface led_shift_driver_if
    import led_drv_pkg::*;
#(
    parameter int WIDTH = LED_WIDTH
);
    logic [WIDTH-1:0] led_in;
    logic             sclk;
    logic             sdo;
    logic             rclk;
    logic             busy;

    // master: the driver (consumes led_in, drives the chain pins)
    modport master (input led_in, output sclk, sdo, rclk, busy);
    // slave: whoever supplies the vector and observes the pins
    modport slave  (output led_in, input sclk, sdo, rclk, busy);
endinterface

// File: rtl/led_shift_driver_phase_counter.sv
// rtl/led_shift_driver_phase_counter.sv - half-period counter with clear and terminal-count pulse
module led_phase_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] div,
    output logic       tc
);
    logic [7:0] phase_cnt;

    // tc marks the last cycle of a div-cycle phase; suppressed while held clear
    assign tc = !clear && (phase_cnt == div - 8'd1);

    // free-running count that wraps on tc so consecutive phases line up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (clear || tc) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/led_shift_driver.sv
// rtl/led_shift_driver.sv - serialises the LED vector to a shift/latch chain; optional LED_REFRESH_EN
module led_shift_driver
    import led_drv_pkg::*;
#(
    parameter int WIDTH          = LED_WIDTH,
    parameter int CLK_DIV        = DEFAULT_CLK_DIV,
    parameter int MSB_FIRST      = 1,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    led_shift_driver_if.master bus
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [7:0]    DIV      = 8'(CLK_DIV);

    led_drv_state_t   state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] shadow;
    logic [BW-1:0]    bit_cnt;
    logic             init_pending;
    logic             start;
    logic             tc;

    led_phase_counter u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .div   (DIV),
        .tc    (tc)
    );

`ifdef LED_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    logic [RW-1:0] refresh_cnt;
    logic          refresh_hit;

    assign refresh_hit = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
    assign start = init_pending || (bus.led_in != shadow) || refresh_hit;

    // idle-time counter; forces a re-send so a corrupted external register heals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (state != IDLE || start) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end
`else
    assign start = init_pending || (bus.led_in != shadow);
`endif

    // rotate rather than shift so the outgoing bit lands where the next read expects it
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
        end else begin
            shift_next = {shift_reg[0], shift_reg[WIDTH-1:1]};
        end
    end

    // frame sequencer with registered pin outputs; sdo only moves as sclk falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            shadow       <= '0;
            bit_cnt      <= '0;
            init_pending <= 1'b1;
            bus.sclk     <= 1'b0;
            bus.sdo      <= 1'b0;
            bus.rclk     <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg    <= bus.led_in;
                        shadow       <= bus.led_in;
                        init_pending <= 1'b0;
                        bus.busy     <= 1'b1;
                        bit_cnt      <= '0;
                        bus.sdo      <= (MSB_FIRST != 0) ? bus.led_in[WIDTH-1] : bus.led_in[0];
                        state        <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tc) begin
                        bus.sclk <= 1'b1;
                        state    <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tc) begin
                        bus.sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            bus.rclk <= 1'b1;
                            state    <= LATCH;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_next;
                            bus.sdo   <= (MSB_FIRST != 0) ? shift_next[WIDTH-1] : shift_next[0];
                            state     <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (tc) begin
                        bus.rclk <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.sdo  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_shift_driver.sv
// tb/tb_led_shift_driver.sv - directed self-checking bench for led_shift_driver
module tb_led_shift_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_shift_driver_if #(.WIDTH(16)) if0 ();
    led_shift_driver_if #(.WIDTH(16)) if1 ();

    led_shift_driver #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master)
    );
    led_shift_driver #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // monitor state, dut0 (MSB first) and dut1 (LSB first)
    logic [15:0] bits0 = '0, bits1 = '0;
    int nb0 = 0, nb1 = 0;
    logic [15:0] fq0[$], fq1[$];
    int busy_q0[$], busy_q1[$], rclk_q0[$], rclk_q1[$];
    int bw0 = 0, bw1 = 0, rw0 = 0, rw1 = 0, hw0 = 0, hw1 = 0, hi_w0 = 0, hi_w1 = 0;
    int rclk_rises0 = 0, viol = 0;
    logic ps0 = 0, pd0 = 0, pr0 = 0, pb0 = 0;
    logic ps1 = 0, pd1 = 0, pr1 = 0, pb1 = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (if0.rclk && !pr0) rclk_rises0++;
        if (!rst_n) begin
            nb0 = 0; bits0 = '0; bw0 = 0; rw0 = 0; hw0 = 0;
            nb1 = 0; bits1 = '0; bw1 = 0; rw1 = 0; hw1 = 0;
        end else begin
            if (if0.sclk && !ps0) begin bits0 = {bits0[14:0], if0.sdo}; nb0++; end
            if (ps0 && if0.sclk && (if0.sdo != pd0)) viol++;
            if (if0.sclk) hw0++; else if (ps0) begin hi_w0 = hw0; hw0 = 0; end
            if (if0.rclk) rw0++;
            if (if0.rclk && !pr0) begin fq0.push_back(bits0); nb0 = 0; end
            if (!if0.rclk && pr0) begin rclk_q0.push_back(rw0); rw0 = 0; end
            if (if0.busy) bw0++; else if (pb0) begin busy_q0.push_back(bw0); bw0 = 0; end

            if (if1.sclk && !ps1) begin bits1 = {if1.sdo, bits1[15:1]}; nb1++; end
            if (ps1 && if1.sclk && (if1.sdo != pd1)) viol++;
            if (if1.sclk) hw1++; else if (ps1) begin hi_w1 = hw1; hw1 = 0; end
            if (if1.rclk) rw1++;
            if (if1.rclk && !pr1) begin fq1.push_back(bits1); nb1 = 0; end
            if (!if1.rclk && pr1) begin rclk_q1.push_back(rw1); rw1 = 0; end
            if (if1.busy) bw1++; else if (pb1) begin busy_q1.push_back(bw1); bw1 = 0; end
        end
        ps0 = if0.sclk; pd0 = if0.sdo; pr0 = if0.rclk; pb0 = if0.busy;
        ps1 = if1.sclk; pd1 = if1.sdo; pr1 = if1.rclk; pb1 = if1.busy;
    end

    task automatic wait_frames0(input int n);
        for (int i = 0; i < 2000 && (fq0.size() < n || if0.busy); i++) @(negedge clk);
    endtask

    task automatic wait_busy0();
        for (int i = 0; i < 50 && !if0.busy; i++) @(negedge clk);
    endtask

    initial begin
        if0.led_in = 16'h0000;
        if1.led_in = 16'h8001;
        repeat (3) @(negedge clk);
        check("rst_sclk", {31'd0, if0.sclk}, 32'd0);
        check("rst_sdo",  {31'd0, if0.sdo},  32'd0);
        check("rst_rclk", {31'd0, if0.rclk}, 32'd0);
        check("rst_busy", {31'd0, if0.busy}, 32'd0);
        rst_n = 1'b1;

        // init frame of zeros (dut0) and 0x8001 LSB-first at CLK_DIV=1 (dut1)
        wait_frames0(1);
        @(negedge clk);
        check("init_count", fq0.size(), 1);
        check("init_data", (fq0.size() > 0) ? fq0[0] : 16'hDEAD, 16'h0000);
        check("init_rclk_w", (rclk_q0.size() > 0) ? rclk_q0[0] : -1, 4);
        check("init_busy_w", (busy_q0.size() > 0) ? busy_q0[0] : -1, 132);
        check("init_sclk_hi_w", hi_w0, 4);
        check("idle_sclk", {31'd0, if0.sclk}, 32'd0);
        check("d1_count", fq1.size(), 1);
        check("d1_data", (fq1.size() > 0) ? fq1[0] : 16'hDEAD, 16'h8001);
        check("d1_busy_w", (busy_q1.size() > 0) ? busy_q1[0] : -1, 33);
        check("d1_rclk_w", (rclk_q1.size() > 0) ? rclk_q1[0] : -1, 1);
        check("d1_sclk_hi_w", hi_w1, 1);
        repeat (60) @(negedge clk);
        check("no_resend", fq0.size(), 1);

        // 0x001F MSB first
        if0.led_in = 16'h001F;
        wait_frames0(2);
        check("f1f_data", (fq0.size() > 1) ? fq0[1] : 16'hDEAD, 16'h001F);
        check("f1f_busy_w", (busy_q0.size() > 1) ? busy_q0[1] : -1, 132);
        repeat (200) @(negedge clk);
        check("f1f_stable", fq0.size(), 2);

        // changes during a frame: 0x0007 must be dropped
        if0.led_in = 16'h0003;
        wait_busy0();
        repeat (20) @(negedge clk);
        if0.led_in = 16'h0007;
        repeat (40) @(negedge clk);
        if0.led_in = 16'h000F;
        wait_frames0(4);
        repeat (200) @(negedge clk);
        check("tog_count", fq0.size(), 4);
        check("tog_first", (fq0.size() > 2) ? fq0[2] : 16'hDEAD, 16'h0003);
        check("tog_second", (fq0.size() > 3) ? fq0[3] : 16'hDEAD, 16'h000F);

        // reset mid-frame at bit 8
        if0.led_in = 16'h00AA;
        wait_busy0();
        for (int i = 0; i < 200 && nb0 < 8; i++) @(negedge clk);
        check("abort_reached", nb0, 8);
        rst_n = 1'b0;
        if0.led_in = 16'h0000;
        #1;
        check("abort_sclk", {31'd0, if0.sclk}, 32'd0);
        check("abort_sdo",  {31'd0, if0.sdo},  32'd0);
        check("abort_rclk", {31'd0, if0.rclk}, 32'd0);
        check("abort_busy", {31'd0, if0.busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frames0(5);
        @(negedge clk);
        check("post_rst_count", fq0.size(), 5);
        check("post_rst_data", (fq0.size() > 4) ? fq0[4] : 16'hDEAD, 16'h0000);
        check("rclk_rises", rclk_rises0, 5);
        check("d1_reinit", (fq1.size() > 1) ? fq1[fq1.size()-1] : 16'hDEAD, 16'h8001);
        check("sdo_stable_hi", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
